uart_tx_arb: RTL

- Round-robin arbiter and sequencer that shares a single UART transmitter among NUM_REQ byte-stream requesters.
- Grants the transmitter to one requester for a whole packet, or until a burst limit, then re-arbitrates.
- Drives the transmitter's enable/data inputs and tracks its busy output, so enable is never pulsed while busy.
- Sits between peripheral/debug byte sources and the UART transmitter in the peripheral subsystem.

---
 rtl/uart_tx_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb
// Purpose  : Round-robin arbiter/sequencer sharing one UART transmitter among
//            NUM_REQ byte-stream requesters. A grant lasts for a whole packet
//            or until MAX_BURST bytes, then the transmitter is re-arbitrated.
//            Optional macro UART_TX_ARB_PRIO_EN makes requester 0 a
//            high-priority source that is exempt from the burst limit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 8,
    parameter int MAX_BURST    = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            grant_active,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    input  logic                            uart_tx_busy
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int CAND_W = ID_W + 1;
    localparam int CNT_W  = $clog2(MAX_BURST + 1);

    localparam logic [ID_W-1:0]  LAST_GRANT_RST = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT    = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [ID_W-1:0]         last_grant, last_grant_nxt;
    logic [ID_W-1:0]         grant_id_nxt;
    logic                    grant_active_nxt;
    logic [CNT_W-1:0]        burst_cnt, burst_cnt_nxt;
    logic                    last_flag, last_flag_nxt;
    logic                    uart_tx_en_nxt;
    logic [PAYLOAD_BITS-1:0] uart_tx_data_nxt;

    logic                    arb_found;
    logic [ID_W-1:0]         arb_pick;
    logic [CAND_W-1:0]       cand;
    logic                    issue_fire;
    logic                    burst_hit;
    logic [PAYLOAD_BITS-1:0] cur_byte;

    assign issue_fire = (state == S_ISSUE) && req_valid[grant_id] && !uart_tx_busy;
    assign cur_byte   = req_data[grant_id*PAYLOAD_BITS +: PAYLOAD_BITS];

    // Burst-limit release; the priority requester is never forced off.
`ifdef UART_TX_ARB_PRIO_EN
    assign burst_hit = (burst_cnt == BURST_LIMIT) && (grant_id != '0);
`else
    assign burst_hit = (burst_cnt == BURST_LIMIT);
`endif

    // Round-robin pick: first valid requester scanning upward from last_grant+1.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + CAND_W'(k);
            if (cand >= CAND_W'(NUM_REQ)) begin
                cand = cand - CAND_W'(NUM_REQ);
            end
            if (!arb_found && req_valid[cand[ID_W-1:0]]) begin
                arb_found = 1'b1;
                arb_pick  = cand[ID_W-1:0];
            end
        end
`ifdef UART_TX_ARB_PRIO_EN
        if (req_valid[0]) begin
            arb_found = 1'b1;
            arb_pick  = '0;
        end
`endif
    end

    // Next-state, grant bookkeeping and transmitter drive.
    always_comb begin
        state_nxt        = state;
        last_grant_nxt   = last_grant;
        grant_id_nxt     = grant_id;
        grant_active_nxt = grant_active;
        burst_cnt_nxt    = burst_cnt;
        last_flag_nxt    = last_flag;
        uart_tx_en_nxt   = 1'b0;
        uart_tx_data_nxt = uart_tx_data;
        req_ready        = '0;

        case (state)
            S_IDLE: begin
                if (arb_found) begin
                    grant_id_nxt     = arb_pick;
                    grant_active_nxt = 1'b1;
                    burst_cnt_nxt    = '0;
                    state_nxt        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Grant is held even if valid drops: packets must complete.
                if (issue_fire) begin
                    req_ready[grant_id] = 1'b1;
                    uart_tx_data_nxt    = cur_byte;
                    uart_tx_en_nxt      = 1'b1;
                    last_flag_nxt       = req_last[grant_id];
                    if (burst_cnt != BURST_LIMIT) begin
                        burst_cnt_nxt = burst_cnt + 1'b1;
                    end
                    state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (uart_tx_busy) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (last_flag || burst_hit) begin
                        last_grant_nxt   = grant_id;
                        grant_active_nxt = 1'b0;
                        state_nxt        = S_IDLE;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            last_grant   <= LAST_GRANT_RST;
            grant_id     <= '0;
            grant_active <= 1'b0;
            burst_cnt    <= '0;
            last_flag    <= 1'b0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            state        <= state_nxt;
            last_grant   <= last_grant_nxt;
            grant_id     <= grant_id_nxt;
            grant_active <= grant_active_nxt;
            burst_cnt    <= burst_cnt_nxt;
            last_flag    <= last_flag_nxt;
            uart_tx_en   <= uart_tx_en_nxt;
            uart_tx_data <= uart_tx_data_nxt;
        end
    end

endmodule
`default_nettype wire
